// File: rtl/mccpu_pkg.sv
// Shared definitions for the multi-cycle CPU controller: state encoding,
// opcodes, datapath select codes and the control-word layout.
package mccpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Moore control word; all-zero is the idle / safe value.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  // True for opcodes the controller knows how to sequence.
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_ADDI)  || (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mccpu_ctrl_if.sv
// Controller-to-datapath bundle: opcode in, control strobes and debug state out.
interface mccpu_ctrl_if;
  logic [5:0] op;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op,
    output PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegWrite, RegDst,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal, state
  );

  modport slave (
    output op,
    input  PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegWrite, RegDst,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal, state
  );
endinterface

// File: rtl/mccpu_ctrl.sv
// Multi-cycle MIPS-subset controller. One state register; the control word
// is registered alongside it as the decode of the next state, so every
// strobe is a glitch-free Moore function of the current state and drops
// to zero the instant rstn is asserted.
module mccpu_ctrl
  import mccpu_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  mccpu_ctrl_if.master  bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  // Control word for a given state; anything not listed stays zero.
  function automatic ctrl_t ctrl_of(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
      end
      // Branch target precomputed into ALUOut while the opcode is examined.
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SL2;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.iord = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.iord       = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_RTYPE_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REG;
        c.alu_op        = ALUOP_SUB;
        c.pc_source     = PCSRC_ALUOUT;
        c.pc_write_cond = 1'b1;
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_source  = PCSRC_JUMP;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic; op is only consulted in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      // Final states and any unused encoding return to FETCH.
      default:    state_d = S_FETCH;
    endcase
  end

  // Control word that will apply in the next state.
  always_comb begin
    ctrl_d = ctrl_of(state_d);
  end

  // State and control registers; async reset parks in IDLE with all strobes low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.PCWrite     = ctrl_q.pc_write;
  assign bus.PCWriteCond = ctrl_q.pc_write_cond;
  assign bus.IorD        = ctrl_q.iord;
  assign bus.MemWrite    = ctrl_q.mem_write;
  assign bus.IRWrite     = ctrl_q.ir_write;
  assign bus.RegWrite    = ctrl_q.reg_write;
  assign bus.RegDst      = ctrl_q.reg_dst;
  assign bus.MemtoReg    = ctrl_q.mem_to_reg;
  assign bus.ALUSrcA     = ctrl_q.alu_src_a;
  assign bus.ALUSrcB     = ctrl_q.alu_src_b;
  assign bus.ALUOp       = ctrl_q.alu_op;
  assign bus.PCSource    = ctrl_q.pc_source;
  assign bus.instr_done  = ctrl_q.instr_done;
  assign bus.state       = state_q;

  // Unsupported opcode flag depends on the live op, so it is not registered.
  assign bus.illegal = (state_q == S_DECODE) && !op_supported(bus.op);

endmodule

// File: tb/tb_mccpu_ctrl.sv
// Directed bench for mccpu_ctrl: the driver queues the expected per-cycle
// state/control word, a negedge monitor pops and compares.
module tb_mccpu_ctrl;

  logic clk;
  logic rstn;

  mccpu_ctrl_if bus();

  mccpu_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word layout: state[20:17], PCWrite, PCWriteCond, IorD, MemWrite, IRWrite,
  // RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB[2], ALUOp[2], PCSource[2],
  // instr_done, illegal.
  localparam logic [20:0] E_IDLE    = {4'd0,  9'b000000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [20:0] E_FETCH   = {4'd1,  9'b100010000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [20:0] E_DECODE  = {4'd2,  9'b000000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [20:0] E_DEC_ILL = {4'd2,  9'b000000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1};
  localparam logic [20:0] E_MEMADR  = {4'd3,  9'b000000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [20:0] E_MEMRD   = {4'd4,  9'b001000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [20:0] E_MEMWB   = {4'd5,  9'b000001010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [20:0] E_MEMWR   = {4'd6,  9'b001100000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [20:0] E_RTEX    = {4'd7,  9'b000000001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam logic [20:0] E_RTWB    = {4'd8,  9'b000001100, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [20:0] E_ADEX    = {4'd9,  9'b000000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [20:0] E_ADWB    = {4'd10, 9'b000001000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [20:0] E_BR      = {4'd11, 9'b010000001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
  localparam logic [20:0] E_J       = {4'd12, 9'b100000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};

  typedef struct {
    string       name;
    logic [20:0] word;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec;
  int   n_bad;

  logic [20:0] act;
  assign act = {bus.state, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemWrite,
                bus.IRWrite, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.instr_done, bus.illegal};

  task automatic check(input string name, input logic [20:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got state=%0d ctl=%b, want state=%0d ctl=%b",
               name, act[20:17], act[16:0], want[20:17], want[16:0]);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, e.word);
      end
    end
  end

  // Apply op for the current cycle, queue the expected word, advance one edge.
  task automatic cyc(input string name, input logic [5:0] op_v, input logic [20:0] want);
    exp_t e;
    bus.op = op_v;
    e.name = name;
    e.word = want;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    rstn   = 1'b0;
    bus.op = 6'b000000;
    @(posedge clk);
    #1;
    cyc("rst_hold0", 6'h00, E_IDLE);
    cyc("rst_hold1", 6'h00, E_IDLE);
    rstn = 1'b1;
    cyc("rst_rel_idle", 6'h00, E_IDLE);

    // R-type; junk ops outside DECODE/MEMADR must be ignored
    cyc("rt.fetch",  6'h3f, E_FETCH);
    cyc("rt.decode", 6'h00, E_DECODE);
    cyc("rt.ex",     6'h23, E_RTEX);
    cyc("rt.wb",     6'h2b, E_RTWB);

    // lw
    cyc("lw.fetch",  6'h23, E_FETCH);
    cyc("lw.decode", 6'h23, E_DECODE);
    cyc("lw.memadr", 6'h23, E_MEMADR);
    cyc("lw.memrd",  6'h2b, E_MEMRD);
    cyc("lw.memwb",  6'h04, E_MEMWB);

    // sw
    cyc("sw.fetch",  6'h2b, E_FETCH);
    cyc("sw.decode", 6'h2b, E_DECODE);
    cyc("sw.memadr", 6'h2b, E_MEMADR);
    cyc("sw.memwr",  6'h00, E_MEMWR);

    // addi
    cyc("addi.fetch",  6'h08, E_FETCH);
    cyc("addi.decode", 6'h08, E_DECODE);
    cyc("addi.ex",     6'h02, E_ADEX);
    cyc("addi.wb",     6'h3f, E_ADWB);

    // beq then j
    cyc("beq.fetch",  6'h04, E_FETCH);
    cyc("beq.decode", 6'h04, E_DECODE);
    cyc("beq.br",     6'h3f, E_BR);
    cyc("j.fetch",    6'h02, E_FETCH);
    cyc("j.decode",   6'h02, E_DECODE);
    cyc("j.jump",     6'h23, E_J);

    // illegal opcodes return straight to FETCH
    cyc("ill.fetch",   6'h3f, E_FETCH);
    cyc("ill.decode",  6'h3f, E_DEC_ILL);
    cyc("ill2.fetch",  6'h01, E_FETCH);
    cyc("ill2.decode", 6'h01, E_DEC_ILL);

    // sw interrupted by asynchronous reset in MEMWR
    cyc("swr.fetch",  6'h00, E_FETCH);
    cyc("swr.decode", 6'h2b, E_DECODE);
    cyc("swr.memadr", 6'h2b, E_MEMADR);
    begin
      exp_t e;
      e.name = "swr.memwr";
      e.word = E_MEMWR;
      sb_q.push_back(e);
    end
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("async_rst_memwr", E_IDLE);
    @(posedge clk);
    #1;
    cyc("async_rst_hold", 6'h00, E_IDLE);
    rstn = 1'b1;
    cyc("post_rst_idle",   6'h08, E_IDLE);
    cyc("post_rst.fetch",  6'h08, E_FETCH);
    cyc("post_rst.decode", 6'h08, E_DECODE);
    cyc("post_rst.ex",     6'h08, E_ADEX);
    cyc("post_rst.wb",     6'h08, E_ADWB);
    cyc("post_rst.fetch2", 6'h00, E_FETCH);

    repeat (3) @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mccpu_ctrl.md
MCCPU_CTRL -- requirements
Module: mccpu_ctrl

Interface
REQ-001 clk  input  1  CPU clock; all state changes occur on the rising edge.
REQ-002 rstn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 op  input  6  opcode field of the instruction register, IR[31:26].
REQ-004 PCWrite  output  1  unconditional PC load.
REQ-005 PCWriteCond  output  1  PC load qualified externally by ALU zero (beq).
REQ-006 IorD  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-007 MemWrite  output  1  unified memory write strobe.
REQ-008 IRWrite  output  1  instruction register load.
REQ-009 RegWrite  output  1  register file write.
REQ-010 RegDst  output  1  write register select: 0=rt, 1=rd.
REQ-011 MemtoReg  output  1  write data select: 0=ALUOut, 1=MDR.
REQ-012 ALUSrcA  output  1  ALU A select: 0=PC, 1=reg A.
REQ-013 ALUSrcB  output  2  ALU B select: 00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-014 ALUOp  output  2  00=add, 01=sub, 10=use funct.
REQ-015 PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-016 instr_done  output  1  one-cycle pulse in the final state of each instruction.
REQ-017 illegal  output  1  high during DECODE when op is unsupported.
REQ-018 state  output  4  current state encoding, for debug and bench observation.

Function
REQ-019 FSM states: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, ADDI_EX, ADDI_WB, BRANCH, JUMP.
REQ-020 State is registered; all outputs except illegal are Moore decodes of state; unlisted outputs are 0.
REQ-021 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-022 FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1; next DECODE.
REQ-023 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next by op: 100011/101011->MEMADR, 000000->RTYPE_EX, 001000->ADDI_EX, 000100->BRANCH, 000010->JUMP, else FETCH with illegal=1.
REQ-024 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD if op=100011, else MEMWR.
REQ-025 MEMRD: IorD=1; next MEMWB.  MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1; next FETCH.
REQ-026 MEMWR: IorD=1, MemWrite=1, instr_done=1; next FETCH.
REQ-027 RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next RTYPE_WB.  RTYPE_WB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1; next FETCH.
REQ-028 ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next ADDI_WB.  ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1; next FETCH.
REQ-029 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1, instr_done=1; next FETCH.
REQ-030 JUMP: PCSource=10, PCWrite=1, instr_done=1; next FETCH.
REQ-031 Cycles per instruction from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; illegal op 2, no architectural write.
REQ-032 op is sampled only in DECODE and MEMADR; changes of op in any other state have no effect.
REQ-033 At most one of RegWrite, MemWrite is high in any cycle; IRWrite is high only in FETCH.
REQ-034 Unused state encodings transition to FETCH on the next edge, with all outputs 0.

Reset
REQ-035 rstn low forces state=IDLE immediately, regardless of clk, with all outputs 0, including mid-instruction (e.g. in MEMWR, MemWrite drops without waiting for an edge).
REQ-036 After rstn rises, the first edge moves IDLE->FETCH; the first IRWrite occurs in the cycle after that edge.

Structure
REQ-037 Package mccpu_pkg holds the state encoding, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J), and ALUOp, ALUSrcB, and PCSource codes.
REQ-038 No sub-module: a single state register plus next-state and output decode, 120-250 lines.

Verification
REQ-039 Reset release, op=000000 -> IDLE, FETCH, DECODE, RTYPE_EX, RTYPE_WB (RegWrite=1, RegDst=1, instr_done=1), FETCH.
REQ-040 op=100011 -> lw path of 5 cycles from FETCH; MEMWB has MemtoReg=1 and RegWrite=1; IorD=1 only in MEMRD.
REQ-041 op=101011 -> MEMWR has MemWrite=1 and instr_done=1; RegWrite is never 1 during the instruction.
REQ-042 op=000100 then op=000010 -> BRANCH has PCWriteCond=1 and PCSource=01; JUMP has PCWrite=1 and PCSource=10; each instruction takes 3 cycles.
REQ-043 op=111111 -> illegal=1 in DECODE, next state FETCH, and no RegWrite/MemWrite.
REQ-044 rstn driven low between edges while in MEMWR -> MemWrite=0 and state=IDLE before the next clk edge.
